path_walker: RTL and testbench
==============================

// Module: path_walker
// PURPOSE
//  Player-token controller sitting directly downstream of the level map register.
//  Takes debounced direction pulses and tracks the token's (h,v) position on the 20x15 map.
//  A move is allowed only onto LINE or TERMINAL cells. Entering TERMINAL raises a win pulse
//  for the game FSM. Position feeds the VGA renderer.
// PARAMETERS
//  START_H   1        start column after reset or level reload (0..19)
//  START_V   1        start row after reset or level reload (0..14)
//  COOLDOWN  8        idle cycles after each evaluated move before new input is accepted (0 allowed)
//  MAX_STEPS 64       step budget, used only with WALKER_STEP_LIMIT_EN
// PORTS
//  clk        in   1    system clock
//  rst        in   1    synchronous, active-high reset
//  state      in   3    game state: 3'b001 PLAY, 3'b010 RELOAD, 3'b011 WIN, 3'b100 LOSE
//  map        in   900  [0:899] cell array; cell (h,v) = {map[i],map[i+1],map[i+2]}, i=(h+20*v)*3
//  dir_valid  in   1    one-cycle direction request
//  dir        in   2    2'd0 up (v-1), 2'd1 down (v+1), 2'd2 left (h-1), 2'd3 right (h+1)
//  pos_h      out  5    current column
//  pos_v      out  4    current row
//  busy       out  1    high whenever FSM != IDLE
//  moved      out  1    one-cycle pulse: position changed
//  blocked    out  1    one-cycle pulse: request rejected (NONE cell or grid edge)
//  reached    out  1    one-cycle pulse: token entered TERMINAL
//  step_cnt   out  8    accepted moves since reset/reload; saturates at 255
//  out_of_steps out 1   level: step budget exhausted (0 without WALKER_STEP_LIMIT_EN)
// BEHAVIOUR
//  - Reset, all synchronous on clk:
//    - pos_h=START_H, pos_v=START_V, step_cnt=0.
//    - moved/blocked/reached/out_of_steps=0; FSM=IDLE.
//    - Reset mid-move aborts with no pulse.
//  - state==RELOAD: same effect as reset, every cycle it is held.
//  - FSM IDLE -> CHECK -> EVAL -> COOL -> IDLE.
//  - IDLE
//    - Accepts dir_valid only when state==PLAY; otherwise dir_valid is ignored.
//    - Captured at edge E0; target coordinate computed and registered.
//  - CHECK
//    - Target cell value registered at E1 (via cell_lookup).
//    - Out-of-grid target (h<0, h>19, v<0, v>14) is flagged as edge.
//  - EVAL, at E2:
//    - Cell LINE(1): pos updated, moved=1, step_cnt+1.
//    - Cell TERMINAL(2): pos updated, moved=1, reached=1, step_cnt+1.
//    - Cell NONE(0), codes 3..7, or edge flag: pos unchanged, blocked=1.
//    - Pulses are high exactly one cycle after E2.
//  - COOL
//    - Counts COOLDOWN cycles, then returns to IDLE.
//    - COOLDOWN=0 goes EVAL -> IDLE directly.
//  - Throughput: one request per 3+COOLDOWN cycles.
//  - dir_valid while busy is dropped, not queued.
//  - Leaving PLAY mid-move: the move completes normally; no new requests are accepted.
//  - Map changes during CHECK: the value registered at E1 decides the move.
//  - step_cnt saturates at 255; it does not wrap.
// CONFIGURATION
//  - WALKER_STEP_LIMIT_EN defined:
//    - When step_cnt reaches MAX_STEPS after a move without reached, out_of_steps goes high.
//    - out_of_steps stays high until reset/RELOAD.
//    - While out_of_steps is high, all requests are ignored.
//    - If the step reaching MAX_STEPS also reaches TERMINAL, out_of_steps stays 0.
//  - WALKER_STEP_LIMIT_EN undefined: out_of_steps tied 0; no budget logic.
// STRUCTURE
//  - Shared package/include map_defs:
//    - Cell codes NONE/LINE/TERMINAL.
//    - MAP_W=20, MAP_H=15, CELL_BITS=3.
//    - Game state codes PLAY/RELOAD/WIN/LOSE.
//    - Direction codes.
//  - Sub-module cell_lookup: combinational 900-bit to 3-bit mux, indexed by (h,v).
//    The MapRenderer reuses it.
//  - FSM, cooldown counter and step counter stay in path_walker.
// TESTING (bench drives the level-1 map unless noted)
//  1 Reset, state=PLAY, dir=right at (1,1) -> target (2,1) LINE; pos=(2,1), moved=1 at E2, step_cnt=1.
//  2 At (1,1), dir=up -> (1,0) NONE; blocked=1, pos stays (1,1), step_cnt unchanged.
//  3 Synthetic map, token at (13,12), dir=up -> (13,11) TERMINAL; reached=1 and moved=1 same cycle.
//  4 dir_valid pulses 1 cycle apart, COOLDOWN=8 -> only first accepted; next accepted 11 cycles later.
//  5 Token at (2,3), state=RELOAD 1 cycle -> pos=(1,1), step_cnt=0; rst asserted in CHECK -> no pulse.
//  6 WALKER_STEP_LIMIT_EN, MAX_STEPS=2, two legal moves -> out_of_steps=1; third request ignored.

Source files
------------

// File: rtl/path_walker_pkg.sv
// ---------------------------------------------------------------------------
// path_walker_pkg
//   Shared map definitions: cell, game-state and direction codes, map geometry.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package path_walker_pkg;

    localparam int MAP_W     = 20;
    localparam int MAP_H     = 15;
    localparam int CELL_BITS = 3;
    localparam int MAP_BITS  = MAP_W * MAP_H * CELL_BITS;

    typedef enum logic [2:0] {
        CELL_NONE     = 3'd0,
        CELL_LINE     = 3'd1,
        CELL_TERMINAL = 3'd2
    } cell_t;

    localparam logic [2:0] GS_PLAY   = 3'b001;
    localparam logic [2:0] GS_RELOAD = 3'b010;
    localparam logic [2:0] GS_WIN    = 3'b011;
    localparam logic [2:0] GS_LOSE   = 3'b100;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_CHECK = 2'd1,
        FSM_EVAL  = 2'd2,
        FSM_COOL  = 2'd3
    } fsm_t;

    // First bit of cell (h,v) in the ascending [0:MAP_BITS-1] map vector.
    function automatic logic [9:0] cell_base(input logic [4:0] h, input logic [3:0] v);
        return (10'(h) + 10'(v) * 10'(MAP_W)) * 10'(CELL_BITS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/path_walker_if.sv
// ---------------------------------------------------------------------------
// path_walker_if
//   Request/position bundle between the game logic and the token controller.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface path_walker_if;

    logic [2:0]                           state;
    logic [0:path_walker_pkg::MAP_BITS-1] map;
    logic                                 dir_valid;
    logic [1:0]                           dir;
    logic [4:0]                           pos_h;
    logic [3:0]                           pos_v;
    logic                                 busy;
    logic                                 moved;
    logic                                 blocked;
    logic                                 reached;
    logic [7:0]                           step_cnt;
    logic                                 out_of_steps;

    modport master (
        output state, map, dir_valid, dir,
        input  pos_h, pos_v, busy, moved, blocked, reached, step_cnt, out_of_steps
    );

    modport slave (
        input  state, map, dir_valid, dir,
        output pos_h, pos_v, busy, moved, blocked, reached, step_cnt, out_of_steps
    );

endinterface

`default_nettype wire

// File: rtl/path_walker_cell_lookup.sv
// ---------------------------------------------------------------------------
// cell_lookup
//   Combinational map mux: returns the 3-bit code of cell (h,v), NONE off-grid.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cell_lookup
    import path_walker_pkg::*;
(
    input  logic [0:MAP_BITS-1] i_map,
    input  logic [4:0]          i_h,
    input  logic [3:0]          i_v,
    output logic [2:0]          o_cell
);

    logic [9:0] w_base;
    logic       w_in_grid;

    assign w_base    = cell_base(i_h, i_v);
    assign w_in_grid = (i_h < 5'(MAP_W)) && (i_v < 4'(MAP_H));

    always_comb begin
        o_cell = CELL_NONE;
        if (w_in_grid) begin
            o_cell = i_map[w_base +: CELL_BITS];
        end
    end

endmodule

`default_nettype wire

// File: rtl/path_walker.sv
// ---------------------------------------------------------------------------
// path_walker
//   Token controller: validates direction requests against the level map and
//   tracks position. Optional step budget via WALKER_STEP_LIMIT_EN.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module path_walker
    import path_walker_pkg::*;
#(
    parameter int START_H   = 1,
    parameter int START_V   = 1,
    parameter int COOLDOWN  = 8,
    parameter int MAX_STEPS = 64
) (
    input  logic          clk,
    input  logic          rst,
    path_walker_if.slave  bus
);

    localparam int c_CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    generate
        if (START_H < 0 || START_H >= MAP_W || START_V < 0 || START_V >= MAP_H ||
            COOLDOWN < 0 || MAX_STEPS < 1 || MAX_STEPS > 255) begin : g_param_err
            $error("path_walker: parameter out of range");
        end
    endgenerate

    fsm_t               r_fsm;
    logic [4:0]         r_pos_h;
    logic [3:0]         r_pos_v;
    logic [4:0]         r_tgt_h;
    logic [3:0]         r_tgt_v;
    logic               r_edge;
    logic [2:0]         r_cell;
    logic [c_CNT_W-1:0] r_cool;
    logic [7:0]         r_steps;
    logic               r_moved;
    logic               r_blocked;
    logic               r_reached;

    logic [4:0]         w_tgt_h;
    logic [3:0]         w_tgt_v;
    logic               w_edge;
    logic [2:0]         w_cell;
    logic [7:0]         w_steps_next;
    logic               w_oos;
    logic               w_accept;
    logic               w_passable;

`ifdef WALKER_STEP_LIMIT_EN
    logic               r_oos;
    assign w_oos = r_oos;
`else
    assign w_oos = 1'b0;
`endif

    // Off-grid targets keep the current position so the lookup index stays legal.
    always_comb begin
        w_tgt_h = r_pos_h;
        w_tgt_v = r_pos_v;
        w_edge  = 1'b0;
        case (bus.dir)
            DIR_UP: begin
                if (r_pos_v == 4'd0) w_edge = 1'b1;
                else                 w_tgt_v = r_pos_v - 4'd1;
            end
            DIR_DOWN: begin
                if (r_pos_v == 4'(MAP_H - 1)) w_edge = 1'b1;
                else                          w_tgt_v = r_pos_v + 4'd1;
            end
            DIR_LEFT: begin
                if (r_pos_h == 5'd0) w_edge = 1'b1;
                else                 w_tgt_h = r_pos_h - 5'd1;
            end
            default: begin
                if (r_pos_h == 5'(MAP_W - 1)) w_edge = 1'b1;
                else                          w_tgt_h = r_pos_h + 5'd1;
            end
        endcase
    end

    cell_lookup u_lookup (
        .i_map  (bus.map),
        .i_h    (r_tgt_h),
        .i_v    (r_tgt_v),
        .o_cell (w_cell)
    );

    assign w_accept     = bus.dir_valid && (bus.state == GS_PLAY) && !w_oos;
    assign w_passable   = !r_edge && (r_cell == CELL_LINE || r_cell == CELL_TERMINAL);
    assign w_steps_next = (r_steps == 8'hFF) ? r_steps : r_steps + 8'd1;

    always_ff @(posedge clk) begin
        if (rst || bus.state == GS_RELOAD) begin
            r_fsm     <= FSM_IDLE;
            r_pos_h   <= 5'(START_H);
            r_pos_v   <= 4'(START_V);
            r_tgt_h   <= 5'(START_H);
            r_tgt_v   <= 4'(START_V);
            r_edge    <= 1'b0;
            r_cell    <= CELL_NONE;
            r_cool    <= '0;
            r_steps   <= 8'd0;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            r_reached <= 1'b0;
`ifdef WALKER_STEP_LIMIT_EN
            r_oos     <= 1'b0;
`endif
        end else begin
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            r_reached <= 1'b0;
            case (r_fsm)
                FSM_IDLE: begin
                    if (w_accept) begin
                        r_tgt_h <= w_tgt_h;
                        r_tgt_v <= w_tgt_v;
                        r_edge  <= w_edge;
                        r_fsm   <= FSM_CHECK;
                    end
                end
                FSM_CHECK: begin
                    r_cell <= w_cell;
                    r_fsm  <= FSM_EVAL;
                end
                FSM_EVAL: begin
                    if (w_passable) begin
                        r_pos_h   <= r_tgt_h;
                        r_pos_v   <= r_tgt_v;
                        r_moved   <= 1'b1;
                        r_reached <= (r_cell == CELL_TERMINAL);
                        r_steps   <= w_steps_next;
`ifdef WALKER_STEP_LIMIT_EN
                        // A winning final step does not count as running out.
                        if (w_steps_next == 8'(MAX_STEPS) && r_cell != CELL_TERMINAL) begin
                            r_oos <= 1'b1;
                        end
`endif
                    end else begin
                        r_blocked <= 1'b1;
                    end
                    if (COOLDOWN == 0) begin
                        r_fsm <= FSM_IDLE;
                    end else begin
                        r_cool <= c_CNT_W'(COOLDOWN - 1);
                        r_fsm  <= FSM_COOL;
                    end
                end
                default: begin
                    if (r_cool == '0) r_fsm  <= FSM_IDLE;
                    else              r_cool <= r_cool - 1'b1;
                end
            endcase
        end
    end

    assign bus.pos_h        = r_pos_h;
    assign bus.pos_v        = r_pos_v;
    assign bus.busy         = (r_fsm != FSM_IDLE);
    assign bus.moved        = r_moved;
    assign bus.blocked      = r_blocked;
    assign bus.reached      = r_reached;
    assign bus.step_cnt     = r_steps;
    assign bus.out_of_steps = w_oos;

endmodule

`default_nettype wire

// File: tb/tb_path_walker.sv
// ---------------------------------------------------------------------------
// tb_path_walker
//   Self-checking bench for path_walker: directed scenarios plus random traffic
//   against a request-timeline reference model.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_path_walker;
    import path_walker_pkg::*;

    localparam int TB_COOL = 8;
    localparam int TB_MAX  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    path_walker_if bus ();
    path_walker_if bus2 ();

    path_walker #(.START_H(1), .START_V(1), .COOLDOWN(TB_COOL), .MAX_STEPS(TB_MAX)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    path_walker #(.START_H(1), .START_V(1), .COOLDOWN(0), .MAX_STEPS(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Map built here, then copied onto the DUT input.
    logic [0:MAP_BITS-1] tmap;

    task automatic set_cell(input int h, input int v, input logic [2:0] c);
        int i;
        i = (h + 20 * v) * 3;
        tmap[i]     = c[2];
        tmap[i + 1] = c[1];
        tmap[i + 2] = c[0];
    endtask

    function automatic logic [2:0] cell_at(input logic [0:MAP_BITS-1] m, input int h, input int v);
        int i;
        if (h < 0 || h > 19 || v < 0 || v > 14) return 3'd0;
        i = (h + 20 * v) * 3;
        return {m[i], m[i + 1], m[i + 2]};
    endfunction

    task automatic build_level1();
        tmap = '0;
        for (int h = 0; h <= 10; h++) set_cell(h, 1, 3'd1);
        for (int v = 2; v <= 5; v++) set_cell(10, v, 3'd1);
        set_cell(10, 6, 3'd2);
        set_cell(2, 2, 3'd1);
        set_cell(2, 3, 3'd1);
    endtask

    // Reference model: a request accepted at edge A looks up the map at A+1,
    // resolves at A+2, and the walker is free again after edge A+2+COOLDOWN.
    int   ec = 0;
    int   acc = 0;
    bit   pend = 0;
    int   th = 0, tv = 0;
    logic [2:0] mcell = 3'd0;
    int   m_h = 1, m_v = 1, m_steps = 0;
    bit   m_oos = 0, m_moved = 0, m_blocked = 0, m_reached = 0;

    task automatic model_edge();
        ec++;
        m_moved = 0; m_blocked = 0; m_reached = 0;
        if (rst || bus.state == GS_RELOAD) begin
            m_h = 1; m_v = 1; m_steps = 0; m_oos = 0; pend = 0;
        end else if (pend) begin
            if (ec == acc + 1) mcell = cell_at(bus.map, th, tv);
            if (ec == acc + 2) begin
                if (mcell == 3'd1 || mcell == 3'd2) begin
                    m_h = th; m_v = tv; m_moved = 1;
                    m_reached = (mcell == 3'd2);
                    if (m_steps < 255) m_steps++;
`ifdef WALKER_STEP_LIMIT_EN
                    if (m_steps == TB_MAX && mcell != 3'd2) m_oos = 1;
`endif
                end else begin
                    m_blocked = 1;
                end
            end
            if (ec == acc + 2 + TB_COOL) pend = 0;
        end else if (bus.dir_valid && bus.state == GS_PLAY && !m_oos) begin
            pend = 1; acc = ec; th = m_h; tv = m_v;
            case (bus.dir)
                2'd0:    tv = m_v - 1;
                2'd1:    tv = m_v + 1;
                2'd2:    th = m_h - 1;
                default: th = m_h + 1;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("pos_h",        int'(bus.pos_h),        m_h);
        chk("pos_v",        int'(bus.pos_v),        m_v);
        chk("busy",         int'(bus.busy),         int'(pend));
        chk("moved",        int'(bus.moved),        int'(m_moved));
        chk("blocked",      int'(bus.blocked),      int'(m_blocked));
        chk("reached",      int'(bus.reached),      int'(m_reached));
        chk("step_cnt",     int'(bus.step_cnt),     m_steps);
        chk("out_of_steps", int'(bus.out_of_steps), int'(m_oos));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Returns right after the resolving edge, with the pulses visible.
    task automatic do_move(input logic [1:0] d);
        bus.dir_valid = 1'b1;
        bus.dir = d;
        tick();
        bus.dir_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic settle();
        repeat (TB_COOL) tick();
    endtask

    task automatic move_full(input logic [1:0] d);
        do_move(d);
        settle();
    endtask

    task automatic reload_with_map();
        bus.state = GS_RELOAD;
        bus.map = tmap;
        tick();
        bus.state = GS_PLAY;
    endtask

    initial begin
        rst = 1'b1;
        bus.state = GS_PLAY; bus.dir_valid = 1'b0; bus.dir = 2'd0;
        build_level1();
        bus.map = tmap;
        bus2.state = GS_RELOAD; bus2.dir_valid = 1'b0; bus2.dir = 2'd0; bus2.map = tmap;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_pos_h", int'(bus.pos_h), 1);
        chk("rst_pos_v", int'(bus.pos_v), 1);
        chk("rst_steps", int'(bus.step_cnt), 0);
        chk("rst_busy",  int'(bus.busy), 0);

        do_move(DIR_RIGHT);
        chk("t1_moved", int'(bus.moved), 1);
        chk("t1_pos_h", int'(bus.pos_h), 2);
        chk("t1_steps", int'(bus.step_cnt), 1);
        settle();

        move_full(DIR_LEFT);
        do_move(DIR_UP);
        chk("t2_blocked", int'(bus.blocked), 1);
        chk("t2_pos_v",   int'(bus.pos_v), 1);
        chk("t2_steps",   int'(bus.step_cnt), 2);
        settle();

        move_full(DIR_LEFT);
        do_move(DIR_LEFT);
        chk("edge_blocked", int'(bus.blocked), 1);
        chk("edge_pos_h",   int'(bus.pos_h), 0);
        settle();
        move_full(DIR_RIGHT);

        // Requests every other cycle: only offsets 0 and 11 may be taken.
        for (int k = 0; k <= 11; k++) begin
            bus.dir_valid = (k % 2 == 0) || (k == 11);
            bus.dir = (k == 0) ? DIR_RIGHT : DIR_DOWN;
            tick();
            if (k == 2)  chk("t4_first_pos_h", int'(bus.pos_h), 2);
            if (k == 10) chk("t4_idle_at_10", int'(bus.busy), 0);
            if (k == 11) chk("t4_accept_at_11", int'(bus.busy), 1);
        end
        bus.dir_valid = 1'b0;
        tick();
        tick();
        chk("t4_second_pos_v", int'(bus.pos_v), 2);
        settle();

        move_full(DIR_DOWN);
        chk("t5_pre_pos_v", int'(bus.pos_v), 3);
        bus.state = GS_RELOAD;
        tick();
        bus.state = GS_PLAY;
        chk("t5_reload_h", int'(bus.pos_h), 1);
        chk("t5_reload_v", int'(bus.pos_v), 1);
        chk("t5_reload_steps", int'(bus.step_cnt), 0);
        bus.dir_valid = 1'b1; bus.dir = DIR_RIGHT;
        tick();
        bus.dir_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_pulse", int'(bus.moved | bus.blocked), 0);
        end
        chk("t5_pos_h", int'(bus.pos_h), 1);

        tmap = '0;
        for (int h = 1; h <= 14; h++) set_cell(h, 1, 3'd1);
        for (int v = 2; v <= 12; v++) set_cell(14, v, 3'd1);
        set_cell(13, 12, 3'd1);
        set_cell(13, 11, 3'd2);
        reload_with_map();
        repeat (13) move_full(DIR_RIGHT);
        repeat (11) move_full(DIR_DOWN);
        move_full(DIR_LEFT);
        do_move(DIR_UP);
        chk("t3_reached", int'(bus.reached), 1);
        chk("t3_moved",   int'(bus.moved), 1);
        chk("t3_pos_v",   int'(bus.pos_v), 11);
        chk("t3_steps",   int'(bus.step_cnt), 26);
        settle();

        // Map edited between acceptance and lookup: the lookup-time value wins.
        build_level1();
        reload_with_map();
        bus.dir_valid = 1'b1; bus.dir = DIR_RIGHT;
        tick();
        bus.dir_valid = 1'b0;
        set_cell(2, 1, 3'd0);
        bus.map = tmap;
        tick();
        build_level1();
        bus.map = tmap;
        tick();
        chk("mapchg_blocked", int'(bus.blocked), 1);
        settle();

        for (int h = 0; h < 20; h++)
            for (int v = 0; v < 15; v++) set_cell(h, v, 3'd1);
        reload_with_map();
        for (int k = 0; k < 260; k++) move_full((k % 2 == 0) ? DIR_RIGHT : DIR_LEFT);
`ifdef WALKER_STEP_LIMIT_EN
        chk("sat_steps", int'(bus.step_cnt), TB_MAX);
        chk("sat_oos",   int'(bus.out_of_steps), 1);
`else
        chk("sat_steps", int'(bus.step_cnt), 255);
        chk("sat_oos",   int'(bus.out_of_steps), 0);
`endif

        for (int h = 0; h < 20; h++)
            for (int v = 0; v < 15; v++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r < 9)       set_cell(h, v, 3'd1);
                else if (r < 11) set_cell(h, v, 3'd2);
                else if (r < 16) set_cell(h, v, 3'd0);
                else             set_cell(h, v, 3'($urandom_range(3, 7)));
            end
        reload_with_map();
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 99);
            if (r < 2)      bus.state = GS_RELOAD;
            else if (r < 5) bus.state = GS_WIN;
            else if (r < 7) bus.state = GS_LOSE;
            else            bus.state = GS_PLAY;
            bus.dir_valid = ($urandom_range(0, 2) == 0);
            bus.dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                set_cell($urandom_range(0, 19), $urandom_range(0, 14), 3'($urandom_range(0, 7)));
                bus.map = tmap;
            end
            tick();
        end
        rst = 1'b0; bus.state = GS_PLAY; bus.dir_valid = 1'b0;

        build_level1();
        bus2.map = tmap;
        bus2.state = GS_PLAY;
        tick();
        for (int m = 0; m < 2; m++) begin
            bus2.dir_valid = 1'b1; bus2.dir = DIR_RIGHT;
            tick();
            bus2.dir_valid = 1'b0;
            tick();
            tick();
            chk("t6_moved", int'(bus2.moved), 1);
        end
        chk("t6_steps", int'(bus2.step_cnt), 2);
`ifdef WALKER_STEP_LIMIT_EN
        chk("t6_oos", int'(bus2.out_of_steps), 1);
`else
        chk("t6_oos", int'(bus2.out_of_steps), 0);
`endif
        bus2.dir_valid = 1'b1; bus2.dir = DIR_RIGHT;
        tick();
        bus2.dir_valid = 1'b0;
`ifdef WALKER_STEP_LIMIT_EN
        chk("t6_third_busy", int'(bus2.busy), 0);
`else
        chk("t6_third_busy", int'(bus2.busy), 1);
`endif
        tick();
        tick();
`ifdef WALKER_STEP_LIMIT_EN
        chk("t6_third_pos_h", int'(bus2.pos_h), 3);
`else
        chk("t6_third_pos_h", int'(bus2.pos_h), 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
